// File: rtl/scan_loader_pkg.sv
// Shared definitions for the scan-chain loader and the memory bank top.
package scan_loader_pkg;

    localparam int BYTE_W = 8;

    // 31 data bytes + valid bit + 7 pad bits + 16-bit tag
    localparam int CHAIN_BITS_DEFAULT = 31 * 8 + 1 + 7 + 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/scan_loader.sv
// Byte-at-a-time scan-chain loader: shifts an image in MSB first while capturing the
// bits falling out of the chain back into bytes.
//   state | meaning
//   IDLE  | waiting for start
//   WAIT  | in_ready high, waiting for the next image byte
//   SHIFT | 8 cycles shifting one byte out and one byte in
//   DONE  | one-cycle done pulse
module scan_loader
    import scan_loader_pkg::*;
#(
    parameter int CHAIN_BITS = CHAIN_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              scan_enable,
    output logic              scan_data_o,
    input  logic              scan_data_i,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CHAIN_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_BITS - 1);

    if (CHAIN_BITS == 0 || (CHAIN_BITS % 8) != 0) begin : g_bad_chain
        $error("CHAIN_BITS must be a nonzero multiple of 8");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] buf_q, buf_d;
    logic [BYTE_W-1:0] cap_q, cap_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              scan_enable_q, scan_enable_d;
    logic              scan_data_o_q, scan_data_o_d;
    logic              done_q, done_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        cap_d         = cap_q;
        out_data_d    = out_data_q;
        out_valid_d   = 1'b0;
        scan_data_o_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    state_d       = S_SHIFT;
                    buf_d         = in_data;
                    scan_data_o_d = in_data[BYTE_W-1];
                end
            end
            S_SHIFT: begin
                buf_d = {buf_q[BYTE_W-2:0], 1'b0};
                cap_d = {cap_q[BYTE_W-2:0], scan_data_i};
                cnt_d = cnt_q + CNT_W'(1);
                // counter advances 8 per byte, so its low bits give the position in the byte
                if (cnt_q[2:0] == 3'b111) begin
                    out_data_d  = {cap_q[BYTE_W-2:0], scan_data_i};
                    out_valid_d = 1'b1;
                    state_d     = (cnt_q == CNT_LAST) ? S_DONE : S_WAIT;
                end else begin
                    scan_data_o_d = buf_q[BYTE_W-2];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d    = (state_d == S_WAIT);
        busy_d        = (state_d != S_IDLE);
        scan_enable_d = (state_d == S_SHIFT);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            buf_q         <= '0;
            cap_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            scan_enable_q <= 1'b0;
            scan_data_o_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            cap_q         <= cap_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            scan_enable_q <= scan_enable_d;
            scan_data_o_q <= scan_data_o_d;
            done_q        <= done_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign scan_enable = scan_enable_q;
    assign scan_data_o = scan_data_o_q;
    assign done        = done_q;
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;

endmodule
